lo_iq_integrator: RTL
=====================

Name: lo_iq_integrator

Overview:
- Downstream consumer of the local-oscillator stage: correlates the channel's 1-bit input bitstream against the 1-bit sin/cos LO outputs.
- Integrates the I and Q products over a fixed window of enabled samples, then dumps signed I/Q sums and an |I|+|Q| magnitude estimate.
- Results are passed to the channel readout through a valid/ready handshake, with a sticky overrun flag.
- One instance per cochlear channel, clocked on the master clock, with sampling gated by a per-core strobe.

Parameters:
- WINDOW_LOG2, 4, log2 of the integration window length N = 2^WINDOW_LOG2 enabled samples (legal range 2..12).
- ACC_W, WINDOW_LOG2+2, derived width of the accumulators, i_out and q_out (signed) and mag_out (unsigned). Not overridden.

Ports:
- clk  input  1  master clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; one sample is consumed per cycle with en=1.
- din  input  1  channel input bitstream sample.
- sin_lo  input  1  in-phase LO bit from the LO stage.
- cos_lo  input  1  quadrature LO bit from the LO stage.
- clr  input  1  synchronous restart of the current window.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- ready  input  1  readout accepts the result.
- valid  output  1  result registers hold an unread result.
- i_out  output  ACC_W  signed in-phase sum.
- q_out  output  ACC_W  signed quadrature sum.
- mag_out  output  ACC_W  unsigned |i_out|+|q_out|.
- overrun  output  1  sticky flag: an unread result was overwritten.

Behaviour:
- Reset (asynchronous, active-high):
  - acc_i, acc_q, sample_cnt, i_out, q_out, mag_out, valid and overrun all go to 0.
  - Every output is 0 until the first dump.
- Per-sample term, evaluated only when en=1:
  - t_i = +1 if din==sin_lo, otherwise -1.
  - t_q = +1 if din==cos_lo, otherwise -1.
  - When en=0, accumulators and counter hold.
- Window counter:
  - sample_cnt is WINDOW_LOG2 bits wide and increments on en, wrapping from N-1 to 0.
- Accumulate (en=1, sample_cnt != N-1):
  - acc_i <= acc_i + t_i; acc_q <= acc_q + t_q.
- Dump (en=1, sample_cnt == N-1):
  - i_out <= acc_i + t_i; q_out <= acc_q + t_q.
  - mag_out <= |acc_i+t_i| + |acc_q+t_q|.
  - acc_i, acc_q and sample_cnt go to 0.
  - valid <= 1.
  - Latency: result visible the cycle after the clock edge that captured the N-th sample.
- Range:
  - Sums lie in [-N, +N]. ACC_W = WINDOW_LOG2+2 covers this and mag_out ≤ 2N without saturation.
  - Full-scale +N and -N must be exact.
- Handshake:
  - Transfer happens on a cycle with valid=1 and ready=1.
  - After a transfer, valid clears on the next edge unless a dump occurs on the same edge.
  - Output registers hold their value while valid=0; they are not cleared after transfer.
- Overrun:
  - Set on a dump edge when valid=1 and ready=0; the new result overwrites the old one.
  - A dump together with ready=1 is not an overrun.
  - Cleared only by clr_ovr=1 or reset.
  - If a set and clr_ovr coincide, the set wins.
- clr:
  - Zeroes acc_i, acc_q and sample_cnt on the next edge and overrides en on that cycle, so no sample is taken and no dump occurs.
  - Does not alter i_out, q_out, mag_out, valid or overrun.
- Reset mid-window: the partial window is discarded and no dump is produced.
- The LO inputs are sampled combinationally with din on the same edge; no internal delay alignment is applied.

Test Plan:
1. WINDOW_LOG2=4, en=1 continuous, din=sin_lo, cos_lo=~sin_lo for 16 samples, ready=1 -> valid pulses one cycle after the 16th sample; i_out=+16, q_out=-16, mag_out=32, overrun=0.
2. din random, sin_lo=cos_lo=din for 8 samples then ~din for 8 samples -> i_out=0, q_out=0, mag_out=0; next window starts from 0.
3. en toggled every other cycle over 32 cycles with din=sin_lo=cos_lo -> exactly one dump, after 16 enabled samples; i_out=q_out=+16; accumulators hold on en=0 cycles.
4. ready=0 across two full windows -> valid stays 1; second result replaces the first; overrun=1 until clr_ovr, then 0. Repeat with ready=1 on the dump cycle -> overrun stays 0.
5. clr asserted after 10 samples of a window, then 16 samples of din=sin_lo -> dump occurs after those 16 samples with i_out=+16; previous outputs and valid are unchanged by clr.
6. Assert reset after 7 samples, then release -> all outputs are 0; the next dump occurs only after 16 new samples.

Source files
------------

// File: rtl/lo_iq_integrator.sv
// ---------------------------------------------------------------------------
// lo_iq_integrator
//
// Correlates a 1-bit channel bitstream against the 1-bit sin/cos outputs of
// the local-oscillator stage. Over a window of N = 2^WINDOW_LOG2 enabled
// samples it sums +1/-1 agreement terms for the I and Q branches. At the end
// of each window it dumps the signed I/Q sums and an |I|+|Q| magnitude
// estimate into result registers. A valid/ready handshake hands each result
// to the channel readout, and a sticky overrun flag records any unread
// result that was overwritten.
//
// Ports:
//   clk      master clock, rising edge
//   reset    asynchronous, active-high reset
//   en       sample strobe, one sample consumed per cycle with en=1
//   din      channel input bitstream sample
//   sin_lo   in-phase LO bit
//   cos_lo   quadrature LO bit
//   clr      synchronous restart of the current window (overrides en)
//   clr_ovr  synchronous clear of the overrun flag
//   ready    readout accepts the current result
//   valid    result registers hold an unread result
//   i_out    signed in-phase sum of the last window
//   q_out    signed quadrature sum of the last window
//   mag_out  unsigned |i_out| + |q_out|
//   overrun  sticky: an unread result was overwritten
// ---------------------------------------------------------------------------
module lo_iq_integrator #(
  parameter  int WINDOW_LOG2 = 4,
  localparam int ACC_W       = WINDOW_LOG2 + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    din,
  input  logic                    sin_lo,
  input  logic                    cos_lo,
  input  logic                    clr,
  input  logic                    clr_ovr,
  input  logic                    ready,
  output logic                    valid,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic        [ACC_W-1:0] mag_out,
  output logic                    overrun
);

  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [ACC_W-1:0] PLUS_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINUS_ONE = '1;

  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
  logic [WINDOW_LOG2-1:0]   sample_cnt_q, sample_cnt_d;
  logic signed [ACC_W-1:0]  i_out_q, i_out_d;
  logic signed [ACC_W-1:0]  q_out_q, q_out_d;
  logic [ACC_W-1:0]         mag_out_q, mag_out_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [ACC_W-1:0]  term_i, term_q;
  logic signed [ACC_W-1:0]  sum_i, sum_q;
  logic [ACC_W-1:0]         abs_i, abs_q;
  logic                     dump;
  logic                     transfer;

  always_comb begin
    term_i   = (din == sin_lo) ? PLUS_ONE : MINUS_ONE;
    term_q   = (din == cos_lo) ? PLUS_ONE : MINUS_ONE;
    sum_i    = acc_i_q + term_i;
    sum_q    = acc_q_q + term_q;
    // Sums stay within [-N, +N], so negation never overflows ACC_W bits and
    // |I|+|Q| <= 2N still fits unsigned in ACC_W bits.
    abs_i    = sum_i[ACC_W-1] ? ACC_W'(-sum_i) : ACC_W'(sum_i);
    abs_q    = sum_q[ACC_W-1] ? ACC_W'(-sum_q) : ACC_W'(sum_q);
    // clr suppresses the sample entirely, including any dump it would cause.
    dump     = en && !clr && (sample_cnt_q == CNT_LAST);
    transfer = valid_q && ready;
  end

  always_comb begin
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    sample_cnt_d = sample_cnt_q;
    i_out_d      = i_out_q;
    q_out_d      = q_out_q;
    mag_out_d    = mag_out_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;

    if (clr) begin
      acc_i_d      = '0;
      acc_q_d      = '0;
      sample_cnt_d = '0;
    end else if (en) begin
      if (dump) begin
        acc_i_d      = '0;
        acc_q_d      = '0;
        sample_cnt_d = '0;
        i_out_d      = sum_i;
        q_out_d      = sum_q;
        mag_out_d    = abs_i + abs_q;
      end else begin
        acc_i_d      = sum_i;
        acc_q_d      = sum_q;
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
    end

    // A dump on the same edge as a transfer re-arms valid for the new result.
    if (dump) begin
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end

    // Setting the flag takes priority over clearing it on the same edge.
    if (dump && valid_q && !ready) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      sample_cnt_q <= '0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      mag_out_q    <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      sample_cnt_q <= sample_cnt_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      mag_out_q    <= mag_out_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign i_out   = i_out_q;
  assign q_out   = q_out_q;
  assign mag_out = mag_out_q;
  assign overrun = overrun_q;

endmodule
